// File: rtl/mmatrix_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : mmatrix_stream_if
// Desc     : Input word stream and output result stream for mmatrix_stream.
//            The slave view belongs to the multiplier and the master view to
//            the block that feeds it and drains it.
// Revision : 1.0 - initial release
// ============================================================================
interface mmatrix_stream_if #(
  parameter int DW = 32,
  parameter int OW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface
`default_nettype wire

// File: rtl/mmatrix_stream.sv
`default_nettype none
// ============================================================================
// Module   : mmatrix_stream
// Desc     : Streaming N x N matrix multiplier, C = A x B. A and then B arrive
//            word by word over a valid/ready port (B optionally column-major).
//            C leaves row-major over a registered valid/ready port. Operands
//            can be signed or unsigned, and the result wraps to OW bits.
// Revision : 1.0 - initial release
// ============================================================================
module mmatrix_stream #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int OW = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            mode_signed,
  input  logic            mode_trans_b,
  output logic            done,
  output logic            idle,
  mmatrix_stream_if.slave strm
);

  // Row and column index width, and the full-precision width of the sum.
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = 2 * DW + $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;

  // Job modes, latched when a start is accepted.
  logic          sgn_q;
  logic          trans_q;

  // Load position: row and column within the current matrix, and a flag that
  // is set once A is complete.
  logic [IW-1:0] ld_row;
  logic [IW-1:0] ld_col;
  logic          ld_b;

  // Index of the C element that the output register loads next.
  logic [IW-1:0] fi;
  logic [IW-1:0] fj;

  logic [DW-1:0] a_mem [N][N];
  logic [DW-1:0] b_mem [N][N];

  logic          ov_q;
  logic          last_q;
  logic [OW-1:0] od_q;

  logic          accept;
  logic          ld_final;
  logic          out_hs;

  logic [SW-1:0] a_ext [N];
  logic [SW-1:0] b_ext [N];
  logic [SW-1:0] prod  [N];
  logic [SW-1:0] dot;

  assign accept   = (state == S_LOAD) && strm.in_valid;
  assign ld_final = accept && ld_b && (ld_row == LAST_IDX) && (ld_col == LAST_IDX);
  assign out_hs   = ov_q && strm.out_ready;

  assign idle          = (state == S_IDLE);
  assign done          = (state == S_DONE);
  assign strm.in_ready = (state == S_LOAD);
  assign strm.out_valid = ov_q;
  assign strm.out_data  = od_q;
  assign strm.out_last  = last_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: IDLE -> LOAD -> CALC -> DONE -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (ld_final) state_nxt = S_CALC;
      S_CALC:  if (out_hs && last_q) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latch the job modes on start and step the load position on every accepted word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sgn_q   <= 1'b0;
      trans_q <= 1'b0;
      ld_row  <= '0;
      ld_col  <= '0;
      ld_b    <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      sgn_q   <= mode_signed;
      trans_q <= mode_trans_b;
      ld_row  <= '0;
      ld_col  <= '0;
      ld_b    <= 1'b0;
    end else if (accept) begin
      if (ld_col == LAST_IDX) begin
        ld_col <= '0;
        if (ld_row == LAST_IDX) begin
          ld_row <= '0;
          ld_b   <= 1'b1;
        end else begin
          ld_row <= ld_row + 1'b1;
        end
      end else begin
        ld_col <= ld_col + 1'b1;
      end
    end
  end

  // Store accepted words. Column-major B swaps row and column on write. The
  // arrays are never cleared because every job reloads them completely.
  always_ff @(posedge clk) begin
    if (reset_n && accept) begin
      if (!ld_b)        a_mem[ld_row][ld_col] <= strm.in_data;
      else if (trans_q) b_mem[ld_col][ld_row] <= strm.in_data;
      else              b_mem[ld_row][ld_col] <= strm.in_data;
    end
  end

  // N parallel multipliers on row fi of A and column fj of B, then summed.
  // Operands are sign- or zero-extended to the full sum width, so the modular
  // product and sum are exact for both modes.
  always_comb begin
    dot = '0;
    for (int k = 0; k < N; k++) begin
      a_ext[k] = {{(SW-DW){sgn_q & a_mem[fi][k][DW-1]}}, a_mem[fi][k]};
      b_ext[k] = {{(SW-DW){sgn_q & b_mem[k][fj][DW-1]}}, b_mem[k][fj]};
      prod[k]  = a_ext[k] * b_ext[k];
      dot      = dot + prod[k];
    end
  end

  // The output keeps only the low OW bits of the sum.
  generate
    if (OW < SW) begin : g_trunc
      logic unused_hi;
      assign unused_hi = ^dot[SW-1:OW];
    end
  endgenerate

  // Output register. C[0][0] is loaded on the edge that takes the last B word.
  // That word is B[N-1][N-1], which C[0][0] does not use. After that, each
  // handshake loads the next element in row-major order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ov_q   <= 1'b0;
      od_q   <= '0;
      last_q <= 1'b0;
      fi     <= '0;
      fj     <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (ld_final) begin
            ov_q   <= 1'b1;
            od_q   <= dot[OW-1:0];
            last_q <= 1'b0;
            fi     <= '0;
            fj     <= IW'(1);
          end
        end
        S_CALC: begin
          if (!ov_q || strm.out_ready) begin
            if (last_q) begin
              ov_q   <= 1'b0;
              od_q   <= '0;
              last_q <= 1'b0;
            end else begin
              ov_q   <= 1'b1;
              od_q   <= dot[OW-1:0];
              last_q <= (fi == LAST_IDX) && (fj == LAST_IDX);
              if (fj == LAST_IDX) begin
                fj <= '0;
                fi <= (fi == LAST_IDX) ? '0 : fi + 1'b1;
              end else begin
                fj <= fj + 1'b1;
              end
            end
          end
        end
        default: begin
          ov_q   <= 1'b0;
          od_q   <= '0;
          last_q <= 1'b0;
          fi     <= '0;
          fj     <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmatrix_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmatrix_stream
// Desc     : Self-checking bench for mmatrix_stream. Two N=4 instances
//            (OW=32 and OW=40) share one stimulus. An N=2, DW=8, OW=8
//            instance runs its own jobs. Every result is compared with a
//            matrix-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmatrix_stream;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        mode_signed;
  logic        mode_trans_b;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_data;
  int          sel;
  logic        start0;
  logic        start2;
  logic        done0, idle0, done1, idle1, done2, idle2;
  bit          ident_chk;

  int n_checks;
  int n_errors;

  logic [31:0] words [0:31];

  always #5 clk = ~clk;

  // Only the selected instance sees start; the other one stays idle.
  assign start0 = start && (sel == 0);
  assign start2 = start && (sel == 1);

  mmatrix_stream_if #(.DW(32), .OW(32)) if0 ();
  mmatrix_stream_if #(.DW(32), .OW(40)) if1 ();
  mmatrix_stream_if #(.DW(8),  .OW(8))  if2 ();

  assign if0.in_valid  = in_valid;
  assign if0.in_data   = in_data;
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.in_data   = in_data;
  assign if1.out_ready = out_ready;
  assign if2.in_valid  = in_valid;
  assign if2.in_data   = in_data[7:0];
  assign if2.out_ready = out_ready;

  mmatrix_stream #(.N(4), .DW(32), .OW(32)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .mode_signed(mode_signed),
    .mode_trans_b(mode_trans_b), .done(done0), .idle(idle0), .strm(if0)
  );
  mmatrix_stream #(.N(4), .DW(32), .OW(40)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start0), .mode_signed(mode_signed),
    .mode_trans_b(mode_trans_b), .done(done1), .idle(idle1), .strm(if1)
  );
  mmatrix_stream #(.N(2), .DW(8), .OW(8)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .mode_signed(mode_signed),
    .mode_trans_b(mode_trans_b), .done(done2), .idle(idle2), .strm(if2)
  );

  // View of whichever instance the current job targets.
  logic        v_idle, v_done, v_in_ready, v_out_valid, v_out_last;
  logic [39:0] v_out_data;
  assign v_idle      = (sel == 1) ? idle2 : idle0;
  assign v_done      = (sel == 1) ? done2 : done0;
  assign v_in_ready  = (sel == 1) ? if2.in_ready  : if0.in_ready;
  assign v_out_valid = (sel == 1) ? if2.out_valid : if0.out_valid;
  assign v_out_last  = (sel == 1) ? if2.out_last  : if0.out_last;
  assign v_out_data  = (sel == 1) ? {32'd0, if2.out_data} : {8'd0, if0.out_data};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Element value as an integer, taken from the low dw bits of a word.
  function automatic logic signed [95:0] elem(input logic [31:0] w, input int dw, input bit sgn);
    logic [31:0]        m;
    logic signed [95:0] v;
    m = (dw == 32) ? w : (w & ((32'd1 << dw) - 32'd1));
    v = $signed({64'd0, m});
    if (sgn && m[dw-1]) v = v - (96'sd1 <<< dw);
    return v;
  endfunction

  // C[i][j] from the word stream: words 0..n*n-1 are A row-major. The rest
  // are B, row-major or column-major. The result keeps the low ow bits.
  function automatic logic [63:0] ref_c(input int n, input int dw, input int ow,
                                        input bit sgn, input bit tr, input int i, input int j);
    logic signed [95:0] acc;
    int                 bidx;
    acc = '0;
    for (int k = 0; k < n; k++) begin
      bidx = tr ? (n*n + j*n + k) : (n*n + k*n + j);
      acc  = acc + elem(words[i*n+k], dw, sgn) * elem(words[bidx], dw, sgn);
    end
    return acc[63:0] & ((64'd1 << ow) - 64'd1);
  endfunction

  // One job on the selected instance. Inputs change on the falling edge and
  // outputs are sampled there. abort_at >= 0 applies reset after that many
  // accepted words.
  task automatic run_job(input int sel_i, input bit sgn, input bit tr, input int gap_pct,
                         input int rdy_pct, input bit abuse, input int abort_at);
    int          n, nw, ne, wi, idx, cyc;
    bit          finished, stall, first_pend, prev_last, acc_in, hs;
    logic [39:0] prev_data;
    n  = (sel_i == 1) ? 2 : 4;
    nw = 2 * n * n;
    ne = n * n;
    sel = sel_i;
    cyc = 0;
    while (!v_idle && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("idle_pre", v_idle, 1);
    start = 1'b1; mode_signed = sgn; mode_trans_b = tr; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_idle", v_idle, 0);
    check_eq("start_in_ready", v_in_ready, 1);
    wi = 0; idx = 0; cyc = 0; finished = 0; stall = 0; first_pend = 0;
    prev_last = 0; prev_data = '0;
    while (!finished && cyc < 3000) begin
      if (stall) begin
        check_eq("stall_valid", v_out_valid, 1);
        check_eq("stall_data", v_out_data, prev_data);
        check_eq("stall_last", v_out_last, prev_last);
      end
      if (first_pend) begin
        check_eq("first_out_latency", v_out_valid, 1);
        first_pend = 0;
      end
      if (!v_out_valid) check_eq("zero_when_invalid", v_out_data, 0);
      out_ready = ($urandom_range(99) < rdy_pct);
      if (wi < nw) begin
        in_valid     = ($urandom_range(99) >= gap_pct);
        in_data      = words[wi];
        mode_signed  = 1'($urandom_range(1));
        mode_trans_b = 1'($urandom_range(1));
      end else begin
        in_valid = 1'($urandom_range(1));
        in_data  = $urandom;
      end
      start  = abuse && (v_in_ready || v_out_valid) && ($urandom_range(7) == 0);
      acc_in = in_valid && v_in_ready;
      hs     = v_out_valid && out_ready;
      if (hs) begin
        if (sel_i == 1) begin
          check_eq("c_n2", v_out_data, ref_c(2, 8, 8, sgn, tr, idx / n, idx % n));
        end else begin
          check_eq("c_ow32", v_out_data, ref_c(4, 32, 32, sgn, tr, idx / n, idx % n));
          check_eq("c_ow40", if1.out_data, ref_c(4, 32, 40, sgn, tr, idx / n, idx % n));
        end
        check_eq("c_last", v_out_last, idx == ne - 1);
        if (ident_chk) check_eq("c_ident", v_out_data, idx);
        idx++;
      end
      stall     = v_out_valid && !out_ready;
      prev_data = v_out_data;
      prev_last = v_out_last;
      if (acc_in) begin
        wi++;
        if (wi == nw) first_pend = 1;
      end
      @(negedge clk);
      cyc++;
      if (acc_in && wi == abort_at) begin
        reset_n = 1'b0; in_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_eq("abort_idle", v_idle, 1);
        check_eq("abort_in_ready", v_in_ready, 0);
        return;
      end
      if (hs && idx == ne) begin
        finished = 1;
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check_eq("done_pulse", v_done, 1);
        check_eq("done_out_valid", v_out_valid, 0);
        @(negedge clk);
        check_eq("done_clear", v_done, 0);
        check_eq("idle_after", v_idle, 1);
      end
    end
    check_eq("job_finished", finished, 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) words[i] = $urandom;
  endtask

  // Stop the run if something hangs.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Main sequence.
  initial begin
    n_checks = 0; n_errors = 0; ident_chk = 0; sel = 0;
    reset_n = 1'b0; start = 1'b0; mode_signed = 1'b0; mode_trans_b = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // Reset held for three cycles with random inputs.
    repeat (3) begin
      start = 1'($urandom_range(1)); in_valid = 1'($urandom_range(1));
      in_data = $urandom; out_ready = 1'($urandom_range(1));
      mode_signed = 1'($urandom_range(1)); mode_trans_b = 1'($urandom_range(1));
      @(negedge clk);
      check_eq("rst_in_ready",  if0.in_ready, 0);
      check_eq("rst_out_valid", if0.out_valid, 0);
      check_eq("rst_out_data",  if1.out_data, 0);
      check_eq("rst_out_last",  if0.out_last, 0);
      check_eq("rst_done",      done0, 0);
      check_eq("rst_idle",      idle0, 1);
      check_eq("rst_idle_n2",   idle2, 1);
      check_eq("rst_valid_n2",  if2.out_valid, 0);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_idle", idle0, 1);
    check_eq("post_rst_idle_n2", idle2, 1);

    // Identity A, B[r][c] = 4r+c, unsigned, no stalls.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        words[r*4+c]    = (r == c) ? 32'd1 : 32'd0;
        words[16+r*4+c] = 32'(4*r + c);
      end
    ident_chk = 1;
    run_job(0, 0, 0, 0, 100, 0, -1);
    ident_chk = 0;

    // Same stream with B column-major.
    run_job(0, 0, 1, 0, 100, 0, -1);

    // All -1 times all 2, signed and then unsigned.
    for (int i = 0; i < 16; i++) begin
      words[i]    = 32'hFFFF_FFFF;
      words[16+i] = 32'd2;
    end
    run_job(0, 1, 0, 0, 100, 0, -1);
    run_job(0, 0, 0, 0, 100, 0, -1);

    // Reset after 10 words, then a complete new job.
    fill_random();
    run_job(0, 0, 0, 20, 70, 0, 10);
    fill_random();
    run_job(0, 1'($urandom_range(1)), 1'($urandom_range(1)), 30, 60, 1, -1);

    // Random data with random input gaps, backpressure and stray starts.
    repeat (4) begin
      fill_random();
      run_job(0, 1'($urandom_range(1)), 1'($urandom_range(1)), 50, 50, 1, -1);
    end

    // N=2, DW=8, OW=8 instance.
    repeat (4) begin
      fill_random();
      run_job(1, 1'($urandom_range(1)), 1'($urandom_range(1)), 40, 50, 1, -1);
    end
    check_eq("n4_idle_during_n2", idle0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
